// File: rtl/conv_pe_pkg.sv
// Shared opcodes, FSM encoding and default widths for the conv PE MAC custom instruction.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package conv_pe_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_LANES  = 4;
  localparam int DEF_ACC_W  = 32;

  localparam logic [1:0] OP_CLR   = 2'd0;
  localparam logic [1:0] OP_MAC   = 2'd1;
  localparam logic [1:0] OP_FLUSH = 2'd2;
  localparam logic [1:0] OP_READ  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_ACC  = 3'd2,
    ST_PUSH = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/conv_pe_mac_instruction_if.sv
// Custom-instruction bus plus the downstream FIFO push port of the conv PE.
// Latency: n/a (wiring only).
// Backpressure: fifo_full from the FIFO side stalls the PE's push.
interface conv_pe_mac_instruction_if;
  import conv_pe_pkg::*;

  logic                              clk_en;
  logic                              start;
  logic [1:0]                        n;
  logic [DEF_DATA_W*DEF_LANES-1:0]   dataa;
  logic [DEF_DATA_W*DEF_LANES-1:0]   datab;
  logic                              done;
  logic [DEF_ACC_W-1:0]              result;
  logic                              fifo_push;
  logic [DEF_ACC_W-1:0]              fifo_data;
  logic                              fifo_full;

  // master is the CPU + FIFO environment, slave is the processing element
  modport master (
    output clk_en, start, n, dataa, datab, fifo_full,
    input  done, result, fifo_push, fifo_data
  );

  modport slave (
    input  clk_en, start, n, dataa, datab, fifo_full,
    output done, result, fifo_push, fifo_data
  );

endinterface

// File: rtl/conv_pe_dot4.sv
// Registered per-lane signed multiply followed by a combinational lane adder.
// Latency: 1 cycle (products registered on load), sum combinational from the product registers.
// Backpressure: none; products hold while load is low.
module conv_pe_dot4 #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int SUM_W  = 2 * DATA_W + $clog2(LANES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic [DATA_W*LANES-1:0]    a,
  input  logic [DATA_W*LANES-1:0]    b,
  output logic signed [SUM_W-1:0]    sum
);

  localparam int PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] prod [LANES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) begin
        prod[i] <= '0;
      end
    end else if (load) begin
      // operands widened first so the product keeps full signed precision
      for (int i = 0; i < LANES; i++) begin
        prod[i] <= PROD_W'($signed(a[i*DATA_W +: DATA_W])) *
                   PROD_W'($signed(b[i*DATA_W +: DATA_W]));
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + SUM_W'(prod[i]);
    end
  end

endmodule

// File: rtl/conv_pe_mac_instruction.sv
// Multi-cycle custom instruction: CLR / MAC (4-lane int8 dot into 32-bit acc) / FLUSH (push acc to FIFO) / READ.
// Latency: CLR/READ done +1, MAC done +3, FLUSH done +2 minimum; clk_en low freezes everything.
// Backpressure: FLUSH waits in PUSH while fifo_full=1; build with CONV_PE_SAT_EN for saturating accumulate + sat_flag.
module conv_pe_mac_instruction
  import conv_pe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                      clk,
  input  logic                      reset,
  conv_pe_mac_instruction_if.slave  bus
`ifdef CONV_PE_SAT_EN
  ,
  output logic                      sat_flag
`endif
);

  localparam int OPND_W = DATA_W * LANES;
  localparam int SUM_W  = 2 * DATA_W + $clog2(LANES);

  state_t                   state;
  state_t                   state_nxt;
  logic [OPND_W-1:0]        a_q;
  logic [OPND_W-1:0]        b_q;
  logic [ACC_W-1:0]         acc;
  logic [ACC_W-1:0]         acc_nxt;
  logic [ACC_W-1:0]         addend;
  logic [ACC_W-1:0]         result_q;
  logic signed [SUM_W-1:0]  dot_sum;
  logic                     start_ok;
  logic                     push_fire;
  logic                     mul_load;
  logic                     done;

  assign start_ok  = bus.clk_en && bus.start && (state == ST_IDLE);
  assign push_fire = bus.clk_en && (state == ST_PUSH) && !bus.fifo_full;
  assign mul_load  = bus.clk_en && (state == ST_MUL);

  conv_pe_dot4 #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .SUM_W  (SUM_W)
  ) u_dot4 (
    .clk   (clk),
    .rst_n (reset),
    .load  (mul_load),
    .a     (a_q),
    .b     (b_q),
    .sum   (dot_sum)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else if (bus.clk_en) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          case (bus.n)
            OP_MAC:   state_nxt = ST_MUL;
            OP_FLUSH: state_nxt = ST_PUSH;
            default:  state_nxt = ST_DONE;
          endcase
        end
      end
      ST_MUL:  state_nxt = ST_ACC;
      ST_ACC:  state_nxt = ST_DONE;
      ST_PUSH: begin
        if (!bus.fifo_full) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign addend = ACC_W'(dot_sum);

`ifdef CONV_PE_SAT_EN
  logic [ACC_W-1:0] sum_wrap;
  logic             ovf;
  logic             sat_q;

  // overflow only when both operands share a sign the wrapped sum lost
  always_comb begin
    sum_wrap = acc + addend;
    ovf      = (acc[ACC_W-1] == addend[ACC_W-1]) && (sum_wrap[ACC_W-1] != acc[ACC_W-1]);
    acc_nxt  = sum_wrap;
    if (ovf) begin
      acc_nxt = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_q <= 1'b0;
    end else if (bus.clk_en) begin
      if ((start_ok && (bus.n == OP_CLR)) || push_fire) begin
        sat_q <= 1'b0;
      end else if ((state == ST_ACC) && ovf) begin
        sat_q <= 1'b1;
      end
    end
  end

  assign sat_flag = sat_q;
`else
  assign acc_nxt = acc + addend;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      result_q <= '0;
    end else if (bus.clk_en) begin
      if (start_ok) begin
        a_q <= bus.dataa;
        b_q <= bus.datab;
        if (bus.n == OP_CLR) begin
          acc      <= '0;
          result_q <= '0;
        end
        if (bus.n == OP_READ) begin
          result_q <= acc;
        end
      end
      if (state == ST_ACC) begin
        acc      <= acc_nxt;
        result_q <= acc_nxt;
      end
      if (push_fire) begin
        result_q <= acc;
        acc      <= '0;
      end
    end
  end

  assign bus.done      = done;
  assign bus.result    = result_q;
  assign bus.fifo_push = push_fire;
  assign bus.fifo_data = acc;

endmodule
